// File: rtl/bolme_denetleyici.sv
// Divider issue controller: resolves RISC-V special cases, sequences the divider, optional one-entry cache (BOLME_ONBELLEK_EN).
// Latency: special case / cache hit 1 cycle after accept; otherwise 1 cycle after the divider done pulse (watchdog ZAMAN_ASIMI).
// Backpressure: istek_hazir_o only in idle; result held stable in SONUC until sonuc_hazir_i, flush drops it.
module bolme_denetleyici #(
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        istek_gecerli_i,
    output logic        istek_hazir_o,
    input  logic [1:0]  islem_i,
    input  logic [31:0] bolunen_i,
    input  logic [31:0] bolen_i,
    input  logic [4:0]  hedef_i,
    input  logic        iptal_i,
    output logic        sonuc_gecerli_o,
    input  logic        sonuc_hazir_i,
    output logic [31:0] sonuc_o,
    output logic [4:0]  sonuc_hedef_o,
    output logic        sonuc_hata_o,
    output logic        bolme_basla_o,
    output logic [1:0]  bolme_islem_o,
    output logic [31:0] bolme_bolunen_o,
    output logic [31:0] bolme_bolen_o,
    input  logic [31:0] bolme_sonuc_i,
    input  logic        bolme_bitti_i
);

    typedef enum logic [1:0] {BOS, BOLUYOR, IPTAL, SONUC} durum_t;

    localparam int SW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);

    durum_t      durum;
    logic [1:0]  islem_q;
    logic [31:0] bolunen_q;
    logic [31:0] bolen_q;
    logic [4:0]  hedef_q;
    logic [31:0] sonuc_q;
    logic        hata_q;
    logic        gecerli_q;
    logic        basla_q;
    logic [SW-1:0] sayac;

    logic        kabul;
    logic        sifira_bolme;
    logic        tasma;
    logic        ozel;
    logic [31:0] ozel_sonuc;
    logic        zaman_doldu;
    logic        onb_isabet;
    logic [31:0] onb_sonuc_q;

    assign istek_hazir_o = (durum == BOS) && !iptal_i;
    assign kabul         = istek_gecerli_i && istek_hazir_o;
    assign sifira_bolme  = (bolen_i == 32'h0);
    // Signed overflow only exists for DIV/REM (islem_i[1] set).
    assign tasma         = islem_i[1] && (bolunen_i == 32'h8000_0000) && (bolen_i == 32'hFFFF_FFFF);
    assign ozel          = sifira_bolme || tasma;
    assign zaman_doldu   = (sayac == SAYAC_SON);

    always_comb begin
        ozel_sonuc = 32'h0;
        if (sifira_bolme)
            ozel_sonuc = islem_i[0] ? bolunen_i : 32'hFFFF_FFFF;
        else if (tasma)
            ozel_sonuc = islem_i[0] ? 32'h0 : 32'h8000_0000;
    end

`ifdef BOLME_ONBELLEK_EN
    logic        onb_gecerli;
    logic [1:0]  onb_islem;
    logic [31:0] onb_bolunen;
    logic [31:0] onb_bolen;

    assign onb_isabet = onb_gecerli && (onb_islem == islem_i) &&
                        (onb_bolunen == bolunen_i) && (onb_bolen == bolen_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            onb_gecerli <= 1'b0;
            onb_islem   <= 2'b0;
            onb_bolunen <= 32'h0;
            onb_bolen   <= 32'h0;
            onb_sonuc_q <= 32'h0;
        end else if ((durum == BOLUYOR || durum == IPTAL) && !bolme_bitti_i && zaman_doldu) begin
            onb_gecerli <= 1'b0;
        end else if (durum == BOLUYOR && bolme_bitti_i && !iptal_i) begin
            onb_gecerli <= 1'b1;
            onb_islem   <= islem_q;
            onb_bolunen <= bolunen_q;
            onb_bolen   <= bolen_q;
            onb_sonuc_q <= bolme_sonuc_i;
        end
    end
`else
    assign onb_isabet  = 1'b0;
    assign onb_sonuc_q = 32'h0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum     <= BOS;
            islem_q   <= 2'b0;
            bolunen_q <= 32'h0;
            bolen_q   <= 32'h0;
            hedef_q   <= 5'h0;
            sonuc_q   <= 32'h0;
            hata_q    <= 1'b0;
            gecerli_q <= 1'b0;
            basla_q   <= 1'b0;
            sayac     <= '0;
        end else begin
            basla_q <= 1'b0;
            case (durum)
                BOS: begin
                    if (kabul) begin
                        islem_q   <= islem_i;
                        bolunen_q <= bolunen_i;
                        bolen_q   <= bolen_i;
                        hedef_q   <= hedef_i;
                        hata_q    <= 1'b0;
                        if (ozel) begin
                            sonuc_q   <= ozel_sonuc;
                            gecerli_q <= 1'b1;
                            durum     <= SONUC;
                        end else if (onb_isabet) begin
                            sonuc_q   <= onb_sonuc_q;
                            gecerli_q <= 1'b1;
                            durum     <= SONUC;
                        end else begin
                            basla_q <= 1'b1;
                            sayac   <= '0;
                            durum   <= BOLUYOR;
                        end
                    end
                end
                BOLUYOR: begin
                    if (iptal_i) begin
                        // The divider keeps running; drain it unless it is already finished.
                        durum <= (bolme_bitti_i || zaman_doldu) ? BOS : IPTAL;
                        sayac <= sayac + SW'(1);
                    end else if (bolme_bitti_i) begin
                        sonuc_q   <= bolme_sonuc_i;
                        gecerli_q <= 1'b1;
                        durum     <= SONUC;
                    end else if (zaman_doldu) begin
                        sonuc_q   <= 32'h0;
                        hata_q    <= 1'b1;
                        gecerli_q <= 1'b1;
                        durum     <= SONUC;
                    end else begin
                        sayac <= sayac + SW'(1);
                    end
                end
                IPTAL: begin
                    if (bolme_bitti_i || zaman_doldu)
                        durum <= BOS;
                    else
                        sayac <= sayac + SW'(1);
                end
                SONUC: begin
                    if (iptal_i || sonuc_hazir_i) begin
                        gecerli_q <= 1'b0;
                        durum     <= BOS;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

    assign sonuc_gecerli_o = gecerli_q;
    assign sonuc_o         = sonuc_q;
    assign sonuc_hedef_o   = hedef_q;
    assign sonuc_hata_o    = hata_q;
    assign bolme_basla_o   = basla_q;
    assign bolme_islem_o   = islem_q;
    assign bolme_bolunen_o = bolunen_q;
    assign bolme_bolen_o   = bolen_q;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Bench for bolme_denetleyici: directed requests, scoreboard queue checked by a monitor, behavioural divider stub.
module tb_bolme_denetleyici;

    localparam int ZA = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        istek_gecerli_i;
    logic        istek_hazir_o;
    logic [1:0]  islem_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic [4:0]  hedef_i;
    logic        iptal_i;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;
    logic [31:0] sonuc_o;
    logic [4:0]  sonuc_hedef_o;
    logic        sonuc_hata_o;
    logic        bolme_basla_o;
    logic [1:0]  bolme_islem_o;
    logic [31:0] bolme_bolunen_o;
    logic [31:0] bolme_bolen_o;
    logic [31:0] bolme_sonuc_i;
    logic        bolme_bitti_i;

    bolme_denetleyici #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .istek_gecerli_i (istek_gecerli_i),
        .istek_hazir_o   (istek_hazir_o),
        .islem_i         (islem_i),
        .bolunen_i       (bolunen_i),
        .bolen_i         (bolen_i),
        .hedef_i         (hedef_i),
        .iptal_i         (iptal_i),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_hazir_i   (sonuc_hazir_i),
        .sonuc_o         (sonuc_o),
        .sonuc_hedef_o   (sonuc_hedef_o),
        .sonuc_hata_o    (sonuc_hata_o),
        .bolme_basla_o   (bolme_basla_o),
        .bolme_islem_o   (bolme_islem_o),
        .bolme_bolunen_o (bolme_bolunen_o),
        .bolme_bolen_o   (bolme_bolen_o),
        .bolme_sonuc_i   (bolme_sonuc_i),
        .bolme_bitti_i   (bolme_bitti_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] sonuc;
        logic [4:0]  hedef;
        logic        hata;
    } beklenen_t;

    beklenen_t bq[$];
    int checks = 0;
    int failures = 0;
    int basla_sayisi = 0;
    int gecikme = 3;
    bit bolucu_sessiz = 1'b0;

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s gercek=%0h beklenen=%0h", ad, gercek, beklenen);
        end
    endtask

    function automatic logic [31:0] bol(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a / b;
            2'b01:   return a % b;
            2'b10:   return $signed(a) / $signed(b);
            default: return $signed(a) % $signed(b);
        endcase
    endfunction

    // Divider stub: answers `gecikme` cycles after seeing the start pulse.
    initial begin
        bolme_bitti_i = 1'b0;
        bolme_sonuc_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (bolme_basla_o && !bolucu_sessiz) begin
                repeat (gecikme) @(posedge clk_i);
                #1;
                bolme_sonuc_i = bol(bolme_islem_o, bolme_bolunen_o, bolme_bolen_o);
                bolme_bitti_i = 1'b1;
                @(posedge clk_i);
                #1;
                bolme_bitti_i = 1'b0;
            end
        end
    end

    // Monitor: counts start pulses and scores every accepted result.
    initial begin
        beklenen_t b;
        forever begin
            @(negedge clk_i);
            if (bolme_basla_o) basla_sayisi++;
            if (rst_ni && sonuc_gecerli_o && sonuc_hazir_i) begin
                checks++;
                if (bq.size() == 0) begin
                    failures++;
                    $display("FAIL sonuc_beklenmeyen sonuc=%0h hedef=%0d hata=%0b", sonuc_o, sonuc_hedef_o, sonuc_hata_o);
                end else begin
                    b = bq.pop_front();
                    if ({sonuc_o, sonuc_hedef_o, sonuc_hata_o} !== b) begin
                        failures++;
                        $display("FAIL sonuc_skor gercek=%0h/%0d/%0b beklenen=%0h/%0d/%0b",
                                 sonuc_o, sonuc_hedef_o, sonuc_hata_o, b.sonuc, b.hedef, b.hata);
                    end
                end
            end
        end
    end

    task automatic istek(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bit kabul = 1'b0;
        islem_i = op; bolunen_i = a; bolen_i = b; hedef_i = tag;
        istek_gecerli_i = 1'b1;
        for (int i = 0; i < 300 && !kabul; i++) begin
            @(negedge clk_i);
            kabul = istek_hazir_o;
            @(posedge clk_i);
            #1;
        end
        istek_gecerli_i = 1'b0;
        if (!kabul) kontrol("istek_kabul_zaman_asimi", 0, 1);
    endtask

    task automatic bosalt();
        for (int i = 0; i < 300 && bq.size() != 0; i++) @(negedge clk_i);
        kontrol("kuyruk_bos", bq.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic bekle_gecerli(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!sonuc_gecerli_o && n < ZA + 20);
        if (!sonuc_gecerli_o) kontrol("gecerli_zaman_asimi", 0, 1);
    endtask

    initial begin
        int b0, n, kotu;
        bit gordu;
        rst_ni = 1'b0;
        istek_gecerli_i = 1'b0; islem_i = 2'b0; bolunen_i = 32'h0; bolen_i = 32'h0;
        hedef_i = 5'h0; iptal_i = 1'b0; sonuc_hazir_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        kontrol("reset_hazir_sirada", istek_hazir_o, 1);
        rst_ni = 1'b1;
        @(negedge clk_i);
        kontrol("reset_hazir", istek_hazir_o, 1);
        kontrol("reset_gecerli", sonuc_gecerli_o, 0);
        kontrol("reset_basla", bolme_basla_o, 0);
        kontrol("reset_sonuc", {sonuc_o, sonuc_hedef_o, sonuc_hata_o}, 0);
        kontrol("reset_bolme_op", {bolme_islem_o, bolme_bolunen_o, bolme_bolen_o}, 0);
        @(posedge clk_i);
        #1;

        // DIVU 41/9 -> 4
        b0 = basla_sayisi;
        bq.push_back('{32'd4, 5'd5, 1'b0});
        istek(2'b00, 32'd41, 32'd9, 5'd5);
        bosalt();
        kontrol("divu_tek_basla", basla_sayisi - b0, 1);

        // Divide by zero and signed overflow: 1-cycle, no start pulse
        b0 = basla_sayisi;
        bq.push_back('{32'hFFFF_FFFF, 5'd1, 1'b0});
        istek(2'b10, 32'd41, 32'd0, 5'd1);
        @(negedge clk_i);
        kontrol("div0_gecikme1", sonuc_gecerli_o, 1);
        bosalt();
        bq.push_back('{32'd41, 5'd2, 1'b0});
        istek(2'b01, 32'd41, 32'd0, 5'd2);
        @(negedge clk_i);
        kontrol("remu0_gecikme1", sonuc_gecerli_o, 1);
        bosalt();
        bq.push_back('{32'h8000_0000, 5'd3, 1'b0});
        istek(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        bosalt();
        bq.push_back('{32'h0, 5'd4, 1'b0});
        istek(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        bosalt();
        kontrol("ozel_basla_yok", basla_sayisi - b0, 0);

        // REM -41/9 flushed 3 cycles after accept
        gecikme = 6;
        istek(2'b11, 32'hFFFF_FFD7, 32'd9, 5'd6);
        repeat (2) begin @(posedge clk_i); #1; end
        iptal_i = 1'b1;
        @(posedge clk_i);
        #1;
        iptal_i = 1'b0;
        gordu = 1'b0; kotu = 0;
        for (int i = 0; i < 40 && !gordu; i++) begin
            @(negedge clk_i);
            if (istek_hazir_o) kotu++;
            if (bolme_bitti_i) gordu = 1'b1;
        end
        kontrol("iptal_bitti_goruldu", gordu, 1);
        kontrol("iptal_hazir_sifir", kotu, 0);
        @(negedge clk_i);
        kontrol("iptal_sonra_hazir", istek_hazir_o, 1);
        @(posedge clk_i);
        #1;
        gecikme = 3;
        bq.push_back('{32'hFFFF_FFFB, 5'd7, 1'b0});
        istek(2'b11, 32'hFFFF_FFD7, 32'd9, 5'd7);
        bosalt();

        // REMU 9/41 under 4 cycles of writeback backpressure
        sonuc_hazir_i = 1'b0;
        bq.push_back('{32'd9, 5'd8, 1'b0});
        istek(2'b01, 32'd9, 32'd41, 5'd8);
        bekle_gecerli(n);
        kotu = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            if (!sonuc_gecerli_o || sonuc_o != 32'd9 || sonuc_hedef_o != 5'd8 || istek_hazir_o) kotu++;
        end
        kontrol("tutma_kararli", kotu, 0);
        @(posedge clk_i);
        #1;
        sonuc_hazir_i = 1'b1;
        bosalt();

        // Silent divider -> watchdog timeout
        bolucu_sessiz = 1'b1;
        bq.push_back('{32'h0, 5'd9, 1'b1});
        istek(2'b00, 32'd100, 32'd7, 5'd9);
        bekle_gecerli(n);
        kontrol("zaman_asimi_en_az", (n >= ZA), 1);
        bosalt();
        bolucu_sessiz = 1'b0;

        // Asynchronous reset mid-division
        gecikme = 6;
        istek(2'b00, 32'd100, 32'd7, 5'd12);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #2;
        kontrol("async_reset_hazir", istek_hazir_o, 1);
        kontrol("async_reset_gecerli", sonuc_gecerli_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (10) begin @(posedge clk_i); #1; end
        gecikme = 3;

        // DIV -41/9 twice: cache hit when enabled
        bq.push_back('{32'hFFFF_FFFC, 5'd10, 1'b0});
        istek(2'b10, 32'hFFFF_FFD7, 32'd9, 5'd10);
        bosalt();
        b0 = basla_sayisi;
        bq.push_back('{32'hFFFF_FFFC, 5'd11, 1'b0});
        istek(2'b10, 32'hFFFF_FFD7, 32'd9, 5'd11);
`ifdef BOLME_ONBELLEK_EN
        @(negedge clk_i);
        kontrol("onbellek_gecikme1", sonuc_gecerli_o, 1);
        bosalt();
        kontrol("onbellek_basla_yok", basla_sayisi - b0, 0);
`else
        bosalt();
        kontrol("onbelleksiz_basla", basla_sayisi - b0, 1);
`endif

        repeat (5) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_zaman_asimi checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench did not finish");
    end

endmodule
